// File: rtl/psr_cond_if.sv
// Handshake/bus bundle between the controller and the PSR/condition unit.
interface psr_cond_if;
  logic       stall;
  logic [1:0] upd_sel;
  logic       c_in;
  logic       l_in;
  logic       f_in;
  logic       z_in;
  logic       n_in;
  logic       psr_we;
  logic [4:0] psr_wdata;
  logic [3:0] cond;
  logic       cond_valid;
  logic       cond_true;
  logic       cond_done;
  logic [4:0] psr_out;
  logic       irq_save;
  logic       irq_restore;
  logic       shadow_valid;
  logic       restore_err;

  modport master (
    output stall, upd_sel, c_in, l_in, f_in, z_in, n_in,
    output psr_we, psr_wdata, cond, cond_valid,
    output irq_save, irq_restore,
    input  cond_true, cond_done, psr_out,
    input  shadow_valid, restore_err
  );

  modport slave (
    input  stall, upd_sel, c_in, l_in, f_in, z_in, n_in,
    input  psr_we, psr_wdata, cond, cond_valid,
    input  irq_save, irq_restore,
    output cond_true, cond_done, psr_out,
    output shadow_valid, restore_err
  );
endinterface

// File: rtl/psr_cond_unit.sv
// PSR capture, condition evaluation and optional interrupt shadow.
// Define PSR_SHADOW_EN to build the one-deep shadow register.
module psr_cond_unit #(
  parameter logic [4:0] RESET_PSR = 5'b00000
) (
  input logic       clk,
  input logic       rst_n,
  psr_cond_if.slave bus
);

  logic [4:0] psr;
  logic [4:0] psr_nxt;
  logic [4:0] upd_mask;
  logic [4:0] upd_val;
  logic [4:0] shadow_q;
  logic       restore_hit;
  logic       cond_true;
  logic       cond_done;

  function automatic logic cond_hit(
    input logic [3:0] code,
    input logic [4:0] p
  );
    logic c, l, f, z, n;
    {n, z, f, l, c} = p;
    unique case (code)
      4'h0: cond_hit = z;
      4'h1: cond_hit = !z;
      4'h2: cond_hit = c;
      4'h3: cond_hit = !c;
      4'h4: cond_hit = l;
      4'h5: cond_hit = !l;
      4'h6: cond_hit = n;
      4'h7: cond_hit = !n;
      4'h8: cond_hit = f;
      4'h9: cond_hit = !f;
      4'hA: cond_hit = !l && !z;
      4'hB: cond_hit = l || z;
      4'hC: cond_hit = !n && !z;
      4'hD: cond_hit = n || z;
      4'hE: cond_hit = 1'b1;
      default: cond_hit = 1'b0;
    endcase
  endfunction

  always_comb begin
    upd_val = {bus.n_in, bus.z_in, bus.f_in,
               bus.l_in, bus.c_in};
    unique case (bus.upd_sel)
      2'b01:   upd_mask = 5'b00101;
      2'b10:   upd_mask = 5'b11010;
      2'b11:   upd_mask = 5'b11111;
      default: upd_mask = 5'b00000;
    endcase
  end

  always_comb begin
    psr_nxt = (psr & ~upd_mask) | (upd_val & upd_mask);
    if (restore_hit)
      psr_nxt = shadow_q;
    else if (bus.psr_we)
      psr_nxt = bus.psr_wdata;
  end

`ifdef PSR_SHADOW_EN
  logic shadow_valid;
  logic restore_err;

  assign restore_hit = bus.irq_restore && shadow_valid;

  // restore outranks save, even when the restore itself misses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q     <= '0;
      shadow_valid <= 1'b0;
      restore_err  <= 1'b0;
    end else if (bus.stall) begin
      restore_err <= 1'b0;
    end else begin
      restore_err <= bus.irq_restore && !shadow_valid;
      if (restore_hit) begin
        shadow_valid <= 1'b0;
      end else if (bus.irq_save && !bus.irq_restore) begin
        shadow_q     <= psr;
        shadow_valid <= 1'b1;
      end
    end
  end

  assign bus.shadow_valid = shadow_valid;
  assign bus.restore_err  = restore_err;
`else
  logic unused_irq;

  assign unused_irq       = bus.irq_save ^ bus.irq_restore;
  assign restore_hit      = 1'b0;
  assign shadow_q         = '0;
  assign bus.shadow_valid = 1'b0;
  assign bus.restore_err  = 1'b0;
`endif

  // evaluation sees the PSR before this edge's update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      psr       <= RESET_PSR;
      cond_true <= 1'b0;
      cond_done <= 1'b0;
    end else if (bus.stall) begin
      cond_done <= 1'b0;
    end else begin
      psr       <= psr_nxt;
      cond_done <= bus.cond_valid;
      if (bus.cond_valid)
        cond_true <= cond_hit(bus.cond, psr);
    end
  end

  assign bus.psr_out   = psr;
  assign bus.cond_true = cond_true;
  assign bus.cond_done = cond_done;

endmodule

// File: tb/tb_psr_cond_unit.sv
// Self-checking bench for psr_cond_unit: model compare plus directed vectors.
module tb_psr_cond_unit;

`ifdef PSR_SHADOW_EN
  localparam bit SH = 1'b1;
`else
  localparam bit SH = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  psr_cond_if bus();

  psr_cond_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // model state: flags as named booleans
  bit       mc, ml, mf, mz, mn;
  bit [4:0] m_sh;
  bit       m_sv, m_ct, m_cd, m_re;
  bit       oc, ol, of_, oz, on_;
  bit       took;

  function automatic bit eval_cond(
    input int code,
    input bit c, input bit l, input bit f,
    input bit z, input bit n
  );
    case (code)
      0:  return z;
      1:  return !z;
      2:  return c;
      3:  return !c;
      4:  return l;
      5:  return !l;
      6:  return n;
      7:  return !n;
      8:  return f;
      9:  return !f;
      10: return !l && !z;
      11: return l || z;
      12: return !n && !z;
      13: return n || z;
      14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit [4:0] pack(
    input bit c, input bit l, input bit f,
    input bit z, input bit n
  );
    return {n, z, f, l, c};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {mn, mz, mf, ml, mc} = 5'b00000;
      m_sh = '0; m_sv = 0; m_ct = 0;
      m_cd = 0; m_re = 0;
    end else if (bus.stall) begin
      m_cd = 0; m_re = 0;
    end else begin
      oc = mc; ol = ml; of_ = mf; oz = mz; on_ = mn;
      m_cd = bus.cond_valid;
      if (bus.cond_valid)
        m_ct = eval_cond(int'(bus.cond), oc, ol, of_, oz, on_);
      m_re = 0;
      took = 0;
      if (SH && bus.irq_restore) begin
        if (m_sv) begin
          {mn, mz, mf, ml, mc} = m_sh;
          m_sv = 0;
          took = 1;
        end else begin
          m_re = 1;
        end
      end else if (SH && bus.irq_save) begin
        m_sh = pack(oc, ol, of_, oz, on_);
        m_sv = 1;
      end
      if (!took) begin
        if (bus.psr_we) begin
          {mn, mz, mf, ml, mc} = bus.psr_wdata;
        end else begin
          if (bus.upd_sel[0]) begin
            mc = bus.c_in; mf = bus.f_in;
          end
          if (bus.upd_sel[1]) begin
            ml = bus.l_in; mz = bus.z_in; mn = bus.n_in;
          end
        end
      end
    end
  end

  task automatic chk(input string name,
                     input logic [4:0] act,
                     input logic [4:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      chk("m_psr", bus.psr_out, pack(mc, ml, mf, mz, mn));
      chk("m_cond_true", {4'b0, bus.cond_true}, {4'b0, m_ct});
      chk("m_cond_done", {4'b0, bus.cond_done}, {4'b0, m_cd});
      chk("m_shadow_valid", {4'b0, bus.shadow_valid}, {4'b0, m_sv});
      chk("m_restore_err", {4'b0, bus.restore_err}, {4'b0, m_re});
    end
  end

  task automatic clr();
    bus.stall = 0; bus.upd_sel = 2'b00;
    bus.c_in = 0; bus.l_in = 0; bus.f_in = 0;
    bus.z_in = 0; bus.n_in = 0;
    bus.psr_we = 0; bus.psr_wdata = '0;
    bus.cond = '0; bus.cond_valid = 0;
    bus.irq_save = 0; bus.irq_restore = 0;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic reset_outs(input string tag);
    chk({tag, "_psr"}, bus.psr_out, 5'b00000);
    chk({tag, "_ct"}, {4'b0, bus.cond_true}, 5'd0);
    chk({tag, "_cd"}, {4'b0, bus.cond_done}, 5'd0);
    chk({tag, "_sv"}, {4'b0, bus.shadow_valid}, 5'd0);
    chk({tag, "_re"}, {4'b0, bus.restore_err}, 5'd0);
  endtask

  logic [4:0] pv [4];
  logic [4:0] p4;

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 0;
    clr();
    repeat (2) tick();
    reset_outs("reset");
    rst_n = 1;

    // 1: all-class update, then EQ
    bus.upd_sel = 2'b11; bus.z_in = 1;
    tick();
    chk("t1_psr", bus.psr_out, 5'b01000);
    clr(); bus.cond = 4'h0; bus.cond_valid = 1;
    tick();
    chk("t1_ct", {4'b0, bus.cond_true}, 5'd1);
    chk("t1_cd", {4'b0, bus.cond_done}, 5'd1);
    clr();
    tick();
    chk("t1_cd_drop", {4'b0, bus.cond_done}, 5'd0);
    chk("t1_ct_hold", {4'b0, bus.cond_true}, 5'd1);

    // 2: arith class keeps Z
    bus.upd_sel = 2'b01; bus.c_in = 1; bus.f_in = 1;
    tick();
    chk("t2_psr", bus.psr_out, 5'b01101);
    clr(); bus.cond = 4'hA; bus.cond_valid = 1;
    tick();
    chk("t2_lo", {4'b0, bus.cond_true}, 5'd0);
    bus.cond = 4'hB;
    tick();
    chk("t2_hs", {4'b0, bus.cond_true}, 5'd1);

    // 3: explicit load beats update
    clr(); bus.psr_we = 1; bus.psr_wdata = 5'b10000;
    bus.upd_sel = 2'b11;
    bus.c_in = 1; bus.l_in = 1; bus.f_in = 1;
    bus.z_in = 1; bus.n_in = 1;
    tick();
    chk("t3_psr", bus.psr_out, 5'b10000);
    clr(); bus.cond = 4'h6; bus.cond_valid = 1;
    tick();
    chk("t3_gt", {4'b0, bus.cond_true}, 5'd1);

    // no bypass: evaluate sees pre-update PSR
    clr(); bus.upd_sel = 2'b10;
    bus.cond = 4'h6; bus.cond_valid = 1;
    tick();
    chk("nobypass_ct", {4'b0, bus.cond_true}, 5'd1);
    chk("nobypass_psr", bus.psr_out, 5'b00000);

    // 4: save with same-cycle update, then restore
    p4 = SH ? 5'b00100 : 5'b00000;
    clr(); bus.psr_we = 1; bus.psr_wdata = 5'b00100;
    tick();
    clr(); bus.irq_save = 1; bus.upd_sel = 2'b11;
    tick();
    chk("t4_psr", bus.psr_out, 5'b00000);
    chk("t4_sv", {4'b0, bus.shadow_valid}, {4'b0, SH});
    clr(); bus.irq_restore = 1;
    tick();
    chk("t4_rest", bus.psr_out, p4);
    chk("t4_sv0", {4'b0, bus.shadow_valid}, 5'd0);

    // 5: restore with empty shadow, then stalled
    tick();
    chk("t5_re", {4'b0, bus.restore_err}, {4'b0, SH});
    chk("t5_psr", bus.psr_out, p4);
    clr();
    tick();
    chk("t5_re_pulse", {4'b0, bus.restore_err}, 5'd0);
    bus.stall = 1; bus.irq_restore = 1;
    bus.upd_sel = 2'b11; bus.z_in = 1;
    bus.cond = 4'hF; bus.cond_valid = 1;
    tick();
    chk("t5_stall_re", {4'b0, bus.restore_err}, 5'd0);
    chk("t5_stall_psr", bus.psr_out, p4);
    chk("t5_stall_cd", {4'b0, bus.cond_done}, 5'd0);

    // restore wins over same-cycle save, and beats psr_we
    clr(); bus.irq_save = 1;
    tick();
    clr(); bus.irq_restore = 1; bus.irq_save = 1;
    bus.psr_we = 1; bus.psr_wdata = 5'b11111;
    tick();
    chk("both_psr", bus.psr_out, SH ? p4 : 5'b11111);
    chk("both_sv", {4'b0, bus.shadow_valid}, 5'd0);

    // condition table sweep over distinct PSR patterns
    pv[0] = 5'b00000; pv[1] = 5'b11111;
    pv[2] = 5'b01010; pv[3] = 5'b10101;
    for (int i = 0; i < 4; i++) begin
      clr(); bus.psr_we = 1; bus.psr_wdata = pv[i];
      tick();
      for (int k = 0; k < 16; k++) begin
        clr(); bus.cond = 4'(k); bus.cond_valid = 1;
        tick();
      end
    end

    // 6: reset lands before a pending evaluation completes
    clr(); bus.cond = 4'hE; bus.cond_valid = 1;
    tick();
    chk("t6_pre", {4'b0, bus.cond_true}, 5'd1);
    #2 rst_n = 0;
    tick();
    reset_outs("t6");
    clr(); rst_n = 1;
    tick();
    chk("t6_cd", {4'b0, bus.cond_done}, 5'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
